// File: rtl/alien_calc_seq.sv
// Sequential sign-magnitude calculator (add/sub/shift-add mul/restoring div)
// with double-dabble BCD conversion and a multiplexed 7-segment display driver.
module alien_calc_seq #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_calculator_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     sw_val1,
    input  logic [WIDTH-1:0]     sw_val2,
    input  logic                 sw_sign1,
    input  logic                 sw_sign2,
    input  logic [1:0]           sw_op,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic                 res_sign,
    output logic [2*WIDTH-1:0]   res_mag,
    output logic [WIDTH-1:0]     rem_mag,
    output logic [7:0]           seg_out,
    output logic [DIGITS-1:0]    digit_en
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(RW + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CONV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_sign;
    logic             b_sign;
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;

    logic [RW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_w;

    logic [RW-1:0]    bin;
    logic [BCD_W-1:0] bcd;
    logic [RW-1:0]    work_mag;
    logic             work_sign;
    logic [WIDTH-1:0] work_rem;
    logic             work_dbz;
    logic [BCD_W-1:0] disp_bcd;

    logic [WIDTH:0]   mul_upper;
    logic [RW-1:0]    prod_step;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH:0]   addsub_mag;
    logic             addsub_sign;

    logic             exec_last;
    logic [RW-1:0]    exec_mag;
    logic             exec_sign;
    logic [WIDTH-1:0] exec_rem;
    logic             exec_dbz;
    logic             conv_last;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_step;

    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] msd;
    logic [3:0]       cur_digit;

    always_ff @(posedge clk or negedge rst_calculator_n) begin
        if (!rst_calculator_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (exec_last) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (conv_last) begin
                    state_next = DONE;
                end
            end
            default: begin
                done       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // One iteration of each multi-cycle algorithm plus the single-cycle add/sub result.
    always_comb begin
        mul_upper = {1'b0, prod[RW-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
        prod_step = {mul_upper, prod[WIDTH-1:1]};

        div_trial = {rem_w, quo[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_mag});
        rem_step  = div_ge ? WIDTH'(div_trial - {1'b0, b_mag}) : div_trial[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], div_ge};

        if (a_sign == b_sign) begin
            addsub_mag  = {1'b0, a_mag} + {1'b0, b_mag};
            addsub_sign = a_sign;
        end else if (a_mag >= b_mag) begin
            addsub_mag  = {1'b0, a_mag - b_mag};
            addsub_sign = a_sign;
        end else begin
            addsub_mag  = {1'b0, b_mag - a_mag};
            addsub_sign = b_sign;
        end
    end

    always_comb begin
        exec_last = 1'b0;
        exec_mag  = '0;
        exec_sign = 1'b0;
        exec_rem  = '0;
        exec_dbz  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                exec_last = 1'b1;
                exec_mag  = RW'(addsub_mag);
                exec_sign = addsub_sign;
            end
            OP_MUL: begin
                exec_last = (cnt == CNT_W'(WIDTH - 1));
                exec_mag  = prod_step;
                exec_sign = a_sign ^ b_sign;
            end
            default: begin
                if (b_mag == '0) begin
                    exec_last = 1'b1;
                    exec_dbz  = 1'b1;
                end else begin
                    exec_last = (cnt == CNT_W'(WIDTH - 1));
                    exec_mag  = RW'(quo_step);
                    exec_rem  = rem_step;
                    exec_sign = a_sign ^ b_sign;
                end
            end
        endcase
        if (exec_mag == '0) begin
            exec_sign = 1'b0;
        end
    end

    // Double-dabble: correct every nibble >= 5 before shifting the next binary bit in.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_step  = BCD_W'({bcd_adj, bin[RW-1]});
        conv_last = (cnt == CNT_W'(RW - 1));
    end

    always_ff @(posedge clk or negedge rst_calculator_n) begin
        if (!rst_calculator_n) begin
            a_mag       <= '0;
            b_mag       <= '0;
            a_sign      <= 1'b0;
            b_sign      <= 1'b0;
            op          <= '0;
            cnt         <= '0;
            prod        <= '0;
            quo         <= '0;
            rem_w       <= '0;
            bin         <= '0;
            bcd         <= '0;
            work_mag    <= '0;
            work_sign   <= 1'b0;
            work_rem    <= '0;
            work_dbz    <= 1'b0;
            disp_bcd    <= '0;
            res_sign    <= 1'b0;
            res_mag     <= '0;
            rem_mag     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_mag       <= sw_val1;
                        b_mag       <= sw_val2;
                        a_sign      <= sw_sign1;
                        b_sign      <= sw_sign2 ^ (sw_op == OP_SUB);
                        op          <= sw_op;
                        prod        <= {{WIDTH{1'b0}}, sw_val2};
                        quo         <= sw_val1;
                        rem_w       <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                EXEC: begin
                    prod  <= prod_step;
                    quo   <= quo_step;
                    rem_w <= rem_step;
                    cnt   <= cnt + CNT_W'(1);
                    if (exec_last) begin
                        cnt       <= '0;
                        bin       <= exec_mag;
                        bcd       <= '0;
                        work_mag  <= exec_mag;
                        work_sign <= exec_sign;
                        work_rem  <= exec_rem;
                        work_dbz  <= exec_dbz;
                    end
                end
                CONV: begin
                    bcd <= bcd_step;
                    bin <= {bin[RW-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    // Publish everything on the same edge so DONE sees a coherent result.
                    if (conv_last) begin
                        cnt         <= '0;
                        disp_bcd    <= bcd_step;
                        res_mag     <= work_mag;
                        res_sign    <= work_sign;
                        rem_mag     <= work_rem;
                        div_by_zero <= work_dbz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_calculator_n) begin
        if (!rst_calculator_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Digits above the most significant nonzero one are blank; the minus sign takes the first blank.
    always_comb begin
        msd       = '0;
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                msd = IDX_W'(i);
            end
            if (scan_idx == IDX_W'(i)) begin
                cur_digit = disp_bcd[4*i +: 4];
            end
        end

        seg_out = 8'hFF;
        if (div_by_zero) begin
            if (scan_idx == '0) begin
                seg_out = 8'h86;
            end
        end else if (scan_idx == '0 || scan_idx <= msd) begin
            seg_out = seg_code(cur_digit);
        end else if (res_sign && scan_idx == msd + IDX_W'(1)) begin
            seg_out = 8'hBF;
        end

        digit_en = ~(DIGITS'(1) << scan_idx);
    end

endmodule
